// File: rtl/mux_rr_nto1.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_nto1
// Purpose  : N_CH:1 valid/ready packet mux, round-robin grant held per packet.
//            Define MUX_FIXED_PRIO_EN for lowest-index-first arbitration.
// Revision : 1.0  initial release
// ============================================================================
module mux_rr_nto1 #(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_grant;
  logic             w_any;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_can_take;
  logic             w_accept;
  logic [N_CH-1:0]  w_ready;

  // Route the locked channel's beat through a decoded mux.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        w_sel_valid = in_valid[i];
        w_sel_last  = in_last[i];
      end
    end
  end

  assign w_can_take = (r_state == ST_LOCKED) && (!r_valid || out_ready);
  assign w_accept   = w_can_take && w_sel_valid;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_ready[i] = w_can_take && (r_sel == SEL_W'(i));
    end
  end

`ifdef MUX_FIXED_PRIO_EN
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_grant = SEL_W'(i);
        w_any   = 1'b1;
      end
    end
  end
`else
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_hi_idx;
  logic [SEL_W-1:0] w_lo_idx;
  logic             w_hi_any;
  logic             w_lo_any;

  // Channels above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (SEL_W'(i) > r_ptr) begin
          w_hi_idx = SEL_W'(i);
          w_hi_any = 1'b1;
        end else begin
          w_lo_idx = SEL_W'(i);
          w_lo_any = 1'b1;
        end
      end
    end
    w_grant = w_hi_any ? w_hi_idx : w_lo_idx;
    w_any   = w_hi_any | w_lo_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SEL_W'(N_CH - 1);
    end else if (w_accept && w_sel_last) begin
      r_ptr <= r_sel;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_accept && w_sel_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_any) begin
        r_sel <= w_grant;
      end
      if (w_accept) begin
        r_data  <= w_sel_data;
        r_last  <= w_sel_last;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_nto1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_nto1
// Purpose  : Self-checking bench for mux_rr_nto1 (directed + random traffic).
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_nto1;

  localparam int N = 4;
  localparam int W = 8;
  localparam logic [6:0] RP = 7'b1001101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;
  logic [1:0]     out_sel;

  logic [47:0]    d3;
  logic [2:0]     v3;
  logic [2:0]     l3;
  logic [2:0]     r3;
  logic [15:0]    od3;
  logic           ov3;
  logic           ol3;
  logic           or3;
  logic [1:0]     os3;

  mux_rr_nto1 #(.N_CH(N), .WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  mux_rr_nto1 #(.N_CH(3), .WIDTH(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d3), .in_valid(v3), .in_last(l3), .in_ready(r3),
    .out_data(od3), .out_valid(ov3), .out_last(ol3),
    .out_ready(or3), .out_sel(os3)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // producer queues: {last, data}
  logic [8:0] pq [N][64];
  int         hd [N];
  int         cnt[N];
  logic [N-1:0] en;

  // reference model
  bit          m_locked;
  int          m_owner;
  int          m_ptr;
  logic        m_ov;
  logic        m_ol;
  logic [W-1:0] m_od;
  logic [N-1:0] m_acc;

  logic         p_ov;
  logic         p_or;
  logic         p_ol;
  logic [W-1:0] p_od;
  logic [W-1:0] log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic l);
    pq[ch][(hd[ch] + cnt[ch]) % 64] = {l, d};
    cnt[ch]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      hd[i]  = 0;
      cnt[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = N - 1;
    m_ov     = 1'b0;
    m_ol     = 1'b0;
    m_od     = '0;
    m_acc    = '0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && cnt[i] > 0) begin
        in_valid[i]        = 1'b1;
        in_data[i*W +: W]  = pq[i][hd[i]][7:0];
        in_last[i]         = pq[i][hd[i]][8];
      end else begin
        in_valid[i]        = 1'b0;
        in_data[i*W +: W]  = '0;
        in_last[i]         = 1'b0;
      end
    end
  endtask

  // Advance the model across one rising edge from the inputs the bench drove.
  task automatic model_edge();
    bit was_locked;
    m_acc = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_locked = m_locked;
    if (was_locked && in_valid[m_owner] && (!m_ov || out_ready)) begin
      m_ov = 1'b1;
      m_od = in_data[m_owner*W +: W];
      m_ol = in_last[m_owner];
      m_acc[m_owner] = 1'b1;
      if (in_last[m_owner]) begin
        m_locked = 1'b0;
        m_ptr    = m_owner;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (!was_locked) begin
      for (int k = 1; k <= N; k++) begin
        int c;
`ifdef MUX_FIXED_PRIO_EN
        c = k - 1;
`else
        c = (m_ptr + k) % N;
`endif
        if (in_valid[c]) begin
          m_owner  = c;
          m_locked = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (m_locked && (!m_ov || out_ready)) exp_rdy[m_owner] = 1'b1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_last", 32'(out_last), 32'(m_ol));
    end
    chk("out_sel", 32'(out_sel), 32'(m_owner));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (p_ov && !p_or) begin
      chk("hold_data", 32'(out_data), 32'(p_od));
      chk("hold_last", 32'(out_last), 32'(p_ol));
    end
    if (out_valid === 1'b1 && out_ready) log_q.push_back(out_data);
    p_ov = out_valid;
    p_or = out_ready;
    p_od = out_data;
    p_ol = out_last;
  endtask

  task automatic step();
    apply_inputs();
    #1;
    compare();
    @(posedge clk);
    model_edge();
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        hd[i] = (hd[i] + 1) % 64;
        cnt[i]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = '0;
    out_ready = 1'b0;
    v3 = '0; l3 = '0; d3 = '0; or3 = 1'b0;
    clear_q();
    model_reset();
    p_ov = 1'b0;
    log_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s_d[$];
    logic [1:0]  s_s[$];
    logic        prevv;

    in_valid = '0; in_last = '0; in_data = '0;
    @(negedge clk);

    // ---- reset values + single channel packet ----
    do_reset();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_last", 32'(out_last), 0);
    chk("rst out_sel", 32'(out_sel), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    en = 4'b0100;
    step();
    chk("t1 sel", 32'(out_sel), 2);
    chk("t1 ov after grant", 32'(out_valid), 0);
    chk("t1 in_ready", 32'(in_ready), 32'h4);
    step();
    chk("t1 beat1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA1});
    step();
    chk("t1 beat2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA2});
    step();
    chk("t1 beat3", {22'd0, out_last, out_valid, out_data}, {22'd0, 1'b1, 1'b1, 8'hA3});
    step();
    chk("t1 drained", 32'(out_valid), 0);
    chk("t1 idle ready", 32'(in_ready), 0);

    // ---- all channels, 1-beat packets ----
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 5; j++) push(i, 8'(8'h10 + i), 1'b1);
    en = 4'b1111;
    prevv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t2 bubble", 32'(out_valid & prevv), 0);
      prevv = out_valid;
    end
    chk("t2 count", 32'(log_q.size() >= 8), 1);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
`ifdef MUX_FIXED_PRIO_EN
      chk("t2 order", 32'(log_q[k]), 32'h10);
`else
      chk("t2 order", 32'(log_q[k]), 32'(8'h10 + (k % 4)));
`endif
    end

    // ---- ch1 packet with back-pressure, ch3 waiting ----
    do_reset();
    push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b0); push(1, 8'hB4, 1'b1);
    push(3, 8'h3C, 1'b1);
    en = 4'b1010;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c < 7) ? RP[6-c] : 1'b1;
      step();
      if (cnt[1] > 0) chk("t3 ch3 blocked", 32'(in_ready[3]), 0);
    end
    chk("t3 beats", 32'(log_q.size()), 5);
    if (log_q.size() == 5) begin
      chk("t3 b0", 32'(log_q[0]), 32'hB1);
      chk("t3 b1", 32'(log_q[1]), 32'hB2);
      chk("t3 b2", 32'(log_q[2]), 32'hB3);
      chk("t3 b3", 32'(log_q[3]), 32'hB4);
      chk("t3 b4", 32'(log_q[4]), 32'h3C);
    end

    // ---- ch0 pauses mid-packet, ch2 waiting ----
    do_reset();
    out_ready = 1'b1;
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b0); push(0, 8'hC3, 1'b1);
    push(2, 8'h2D, 1'b1);
    for (int c = 0; c < 20; c++) begin
      en = {2'b01, !(c >= 3 && c <= 5), 1'b1} & 4'b0101;
      en[0] = !(c >= 3 && c <= 5);
      step();
      if (cnt[0] > 0) begin
        chk("t4 sel locked", 32'(out_sel), 0);
        chk("t4 ch2 blocked", 32'(in_ready[2]), 0);
      end
    end
    chk("t4 beats", 32'(log_q.size()), 5);
    if (log_q.size() == 5) begin
      chk("t4 last beat ch0", 32'(log_q[3]), 32'hC3);
      chk("t4 then ch2", 32'(log_q[4]), 32'h2D);
    end

    // ---- asynchronous reset mid-packet ----
    do_reset();
    out_ready = 1'b1;
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b0); push(3, 8'hD2, 1'b0); push(3, 8'hD3, 1'b1);
    en = 4'b1000;
    step();
    step();
    chk("t5 beat1 out", 32'(out_data), 32'hD0);
    rst_n = 1'b0;
    #1;
    chk("t5 rst ov", 32'(out_valid), 0);
    chk("t5 rst rdy", 32'(in_ready), 0);
    model_reset();
    clear_q();
    en = '0;
    p_ov = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t5 no beat", 32'(out_valid), 0);
    end
    log_q.delete();
    push(0, 8'h0E, 1'b1); push(3, 8'h3E, 1'b1);
    en = 4'b1001;
    step();
    chk("t5 grant ch0", 32'(out_sel), 0);
    step();
    chk("t5 first beat", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h0E});

    // ---- 3-channel 16-bit instance ----
    do_reset();
    v3 = 3'b101; l3 = 3'b111; d3 = {16'hC002, 16'hC001, 16'hC000}; or3 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (ov3) begin
        s_d.push_back(od3);
        s_s.push_back(os3);
      end
    end
    v3 = '0;
    chk("t6 count", 32'(s_d.size() >= 4), 1);
    for (int k = 0; k < 4 && k < s_d.size(); k++) begin
`ifdef MUX_FIXED_PRIO_EN
      chk("t6 sel", 32'(s_s[k]), 0);
      chk("t6 data", 32'(s_d[k]), 32'hC000);
`else
      chk("t6 sel", 32'(s_s[k]), (k % 2 == 0) ? 0 : 2);
      chk("t6 data", 32'(s_d[k]), (k % 2 == 0) ? 32'hC000 : 32'hC002);
`endif
    end

    // ---- random traffic against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (cnt[i] == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = int'($urandom_range(1, 5));
          for (int b = 0; b < len; b++) push(i, 8'($urandom), (b == len - 1));
        end
        en[i] = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand traffic flowed", 32'(log_q.size() > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
